// File: rtl/high_score_keeper.sv
// Best-score tracker for the Running-man HUD.
// Compares a snapshot against the stored best, MSD first.
module high_score_keeper #(
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] score_bcd,
  input  logic        game_over,
  input  logic        show_best,
  output logic [23:0] best_bcd,
  output logic [23:0] disp_bcd,
  output logic        new_record,
  output logic        record_blink,
  output logic        busy
);

  localparam int CW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] CNT_TOP = CW'(BLINK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    UPDATE
  } state_e;

  state_e        state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [23:0]   snap_q, snap_d;
  logic [23:0]   best_q, best_d;
  logic          go_prev_q;
  logic          rec_q, rec_d;
  logic          blink_q;
  logic [CW-1:0] cnt_q;
  logic          start;
  logic [4:0]    bit_lo;
  logic [3:0]    dig_a, dig_b;

  assign start  = game_over & ~go_prev_q;
  assign bit_lo = {idx_q, 2'b00};
  assign dig_a  = snap_q[bit_lo +: 4];
  assign dig_b  = best_q[bit_lo +: 4];

  assign best_bcd     = best_q;
  assign disp_bcd     = show_best ? best_q : score_bcd;
  assign new_record   = rec_q;
  assign record_blink = blink_q;
  assign busy         = (state_q == SCAN) || (state_q == UPDATE);

  // Next-state logic: snapshot, digit walk, best write-back.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    snap_d  = snap_q;
    best_d  = best_q;
    rec_d   = rec_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          snap_d  = score_bcd;
          idx_d   = 3'd5;
          rec_d   = 1'b0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (dig_a > dig_b) begin
          state_d = UPDATE;
        end else if (dig_a < dig_b) begin
          state_d = IDLE;
        end else if (idx_q == 3'd0) begin
          state_d = IDLE;
        end else begin
          idx_d = idx_q - 3'd1;
        end
      end
      UPDATE: begin
        best_d  = snap_q;
        rec_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and edge-detect registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      idx_q     <= 3'd0;
      snap_q    <= 24'd0;
      best_q    <= 24'd0;
      go_prev_q <= 1'b0;
      rec_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      snap_q    <= snap_d;
      best_q    <= best_d;
      go_prev_q <= game_over;
      rec_q     <= rec_d;
    end
  end

  // Blink divider; held clear unless the record flag is steadily set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      blink_q <= 1'b0;
    end else if (!rec_d || !rec_q) begin
      cnt_q   <= '0;
      blink_q <= 1'b0;
    end else if (cnt_q == CNT_TOP) begin
      cnt_q   <= '0;
      blink_q <= ~blink_q;
    end else begin
      cnt_q   <= cnt_q + 1'b1;
    end
  end

endmodule

// File: doc/high_score_keeper.md
# high_score_keeper

Downstream of the six-digit BCD score counter in the Running-man datapath. It snapshots the running score when a game ends and compares it digit by digit against the stored best score, most significant digit first. When the new score is strictly higher, it overwrites the best score and raises a record flag with a blink output for the HUD. It also supplies the 24-bit BCD word that the hex decoders display: either the live score or the best score.

## Interface
Parameters:
- BLINK_DIV, default 25_000_000: clk cycles per half-period of record_blink (0.5 s at 50 MHz); must be ≥ 2.

Ports:
- clk, input, 1: system clock (same 50 MHz clock as the score counter).
- reset, input, 1: asynchronous active-low reset.
- score_bcd, input, 24: live score from the counter; [3:0] = digit 0 (ones), … [23:20] = digit 5.
- game_over, input, 1: level from the game controller; a rising edge ends the game.
- show_best, input, 1: display select; 1 = best score, 0 = live score.
- best_bcd, output, 24: stored best score, same packing as score_bcd.
- disp_bcd, output, 24: show_best ? best_bcd : score_bcd (combinational).
- new_record, output, 1: last completed comparison produced a new best.
- record_blink, output, 1: toggles every BLINK_DIV cycles while new_record = 1; 0 otherwise.
- busy, output, 1: comparison or update in progress.

## Operation
- Edge detect:
  - go_prev is registered from game_over every cycle, in every state.
  - start = game_over & ~go_prev.
- FSM states: IDLE, SCAN, UPDATE.
- IDLE, when start = 1:
  - snap ← score_bcd.
  - idx ← 5.
  - new_record ← 0.
  - state → SCAN.
- SCAN, one digit per cycle, comparing a = snap[idx], b = best[idx] as unsigned 4-bit values:
  - a > b → UPDATE.
  - a < b → IDLE (no record).
  - a == b and idx == 0 → IDLE. A tie is not a record.
  - a == b and idx > 0 → idx ← idx−1, stay in SCAN.
- UPDATE:
  - best_bcd ← snap.
  - new_record ← 1.
  - state → IDLE.
- start is ignored in SCAN and UPDATE. An edge that occurs while busy is lost; it is not queued.
- snap is frozen during SCAN/UPDATE, so changes on score_bcd after the edge have no effect.
- Digits > 9 receive no BCD correction and are compared as plain 4-bit values.
- Blink:
  - While new_record = 1, a counter runs 0…BLINK_DIV−1; at the terminal count it wraps to 0 and record_blink toggles.
  - When new_record = 0, counter = 0 and record_blink = 0.
- new_record stays set until the next start or reset.

## Timing
- Reset values (asynchronous, reset = 0): state = IDLE, idx = 0, snap = 0, best_bcd = 0, go_prev = 0, new_record = 0, record_blink = 0, blink counter = 0, busy = 0.
- Reset asserted mid-SCAN or mid-UPDATE: best_bcd returns to 0 and no partial write occurs.
- start is sampled at clock edge k:
  - snap is loaded at edge k; busy = 1 from edge k.
  - Digit 5 is decided at edge k+1; digit i is decided at edge k+6−i.
- Record path:
  - A record found at digit i moves to UPDATE at edge k+6−i.
  - best_bcd and new_record update at edge k+7−i.
  - Best case: best_bcd updates at k+2. Worst case: k+7.
- No-record path: IDLE is reached at edge k+6−i. For a full tie, that is k+6.
- busy = 1 exactly in SCAN and UPDATE, decoded from state.
- First record_blink toggle occurs BLINK_DIV cycles after new_record rises.
- disp_bcd has zero latency. When best_bcd is selected, disp_bcd changes in the same cycle that best_bcd updates.
- game_over held high produces exactly one start. A new start requires a low cycle first.

## Test plan
- **Reset then record.** Release reset; best = 000000. Set score_bcd = 0x000123 and pulse game_over → record found at digit 2; best_bcd = 0x000123 at edge k+5; new_record = 1; busy high for edges k..k+4, i.e. 5 cycles.
- **Lower score.** best = 0x000123. Score 0x000099 → decision at digit 2, IDLE at k+4; best unchanged; new_record = 0.
- **Tie and late difference.**
  - Score 0x000123 against best 0x000123 → IDLE at k+6, no record.
  - Score 0x000124 → best_bcd = 0x000124 at k+7.
- **Edge handling.**
  - game_over held high for 20 cycles → exactly one comparison.
  - A second rising edge during SCAN → ignored.
  - score_bcd changed after the edge → result uses the snapshot.
- **Blink and display (BLINK_DIV = 4).**
  - After a record, record_blink toggles every 4 cycles.
  - A new start clears new_record and record_blink.
  - show_best toggling switches disp_bcd between best_bcd and score_bcd in the same cycle.
- **Reset mid-SCAN.** Assert reset at k+2 → best_bcd = 0, busy = 0, state IDLE immediately; the next start after release works normally.
